// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns HI/LO and drives the
// hazard unit's ALU_stall/ALU_done handshake.
module ex_muldiv_unit #(
    parameter int MUL_LAT   = 3,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | no operation in flight; MTHI/MTLO write here
    // MUL   | waiting out the multiplier latency
    // DIV   | one restoring-division quotient bit per cycle
    // DONE  | result visible on hi/lo, done pulse
    // HOLD  | EX still stalled after DONE; same instruction still present
    typedef enum logic [2:0] {IDLE, MUL, DIV, DONE, HOLD} state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_ITERS - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic        sgn;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] quo;
    logic [31:0] rem;

    logic        is_mul_op;
    logic        is_div_op;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] dvs;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] sub;
    logic [31:0] q_step;
    logic [31:0] r_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] a_mag;

    assign is_mul_op = (op[2:1] == 2'b00);
    assign is_div_op = (op[2:1] == 2'b01);

    assign stall_req = (state == IDLE && start && !op[2] && !flush)
                     || state == MUL || state == DIV;
    assign busy = (state != IDLE);

    // Sign-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
    assign ext_a = {{32{sgn & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    assign a_mag   = (!op[0] && a[31]) ? -a : a;
    assign dvs     = (sgn && b_q[31]) ? -b_q : b_q;
    assign shifted = {rem, quo[31]};
    assign ge      = (shifted >= {1'b0, dvs});
    // When ge holds the difference is below dvs, so 32 bits suffice.
    assign sub     = shifted[31:0] - dvs;
    assign q_step  = {quo[30:0], ge};
    assign r_step  = ge ? sub : shifted[31:0];
    assign q_fix   = (sgn && (a_q[31] ^ b_q[31])) ? -q_step : q_step;
    assign r_fix   = (sgn && a_q[31]) ? -r_step : r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sgn   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            quo   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (is_mul_op) begin
                                a_q   <= a;
                                b_q   <= b;
                                sgn   <= ~op[0];
                                cnt   <= MUL_LOAD;
                                state <= MUL;
                            end else if (is_div_op) begin
                                a_q   <= a;
                                b_q   <= b;
                                sgn   <= ~op[0];
                                quo   <= a_mag;
                                rem   <= '0;
                                cnt   <= DIV_LOAD;
                                state <= DIV;
                            end else if (op == 3'd4) begin
                                hi <= a;
                            end else if (op == 3'd5) begin
                                lo <= a;
                            end
                        end
                    end
                    MUL: begin
                        if (cnt == 6'd0) begin
                            hi    <= prod[63:32];
                            lo    <= prod[31:0];
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    DIV: begin
                        quo <= q_step;
                        rem <= r_step;
                        if (cnt == 6'd0) begin
                            if (b_q == 32'd0) begin
                                hi <= a_q;
                                lo <= 32'hFFFF_FFFF;
                            end else begin
                                hi <= r_fix;
                                lo <= q_fix;
                            end
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    DONE: state <= ex_stall ? HOLD : IDLE;
                    HOLD: if (!ex_stall) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
